// File: rtl/sgbm_agg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sgbm_agg_pkg
// Purpose  : Shared SGM aggregation constants, cost types and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sgbm_agg_pkg;

   localparam int DISP   = 96;
   localparam int COST_W = 9;
   localparam int P1     = 10;
   localparam int P2     = 120;
   localparam int LAT    = 4;

   localparam int BUS_W  = DISP * COST_W;
   localparam int SUM_W  = COST_W + 2;
   localparam int GRP    = 8;
   localparam int NGRP   = DISP / GRP;

   typedef logic [COST_W-1:0] cost_t;
   typedef logic [BUS_W-1:0]  cost_bus_t;

   localparam cost_t COST_MAX = '1;
   localparam cost_t P1_C     = cost_t'(P1);
   localparam cost_t P2_C     = cost_t'(P2);

   function automatic cost_t sat_add(input cost_t a, input cost_t b);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(b);
      return (sum > SUM_W'(COST_MAX)) ? COST_MAX : sum[COST_W-1:0];
   endfunction

   function automatic cost_t elem(input cost_bus_t bus, input int d);
      return bus[d*COST_W +: COST_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_min_tree.sv
`default_nettype none
// ============================================================================
// Module   : disp_min_tree
// Purpose  : Combinational minimum over N packed W-bit elements (binary tree).
// Revision : 1.0 - initial release
// ============================================================================
module disp_min_tree #(
   parameter int N = 8,
   parameter int W = 9
) (
   input  logic [N*W-1:0] data,
   output logic [W-1:0]   min_val
);

   // Heap-ordered tree: leaves at [N-1 .. 2N-2], root at 0.
   logic [W-1:0] node [2*N-1];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         node[N-1+i] = data[i*W +: W];
      end
      for (int i = N-2; i >= 0; i--) begin
         node[i] = (node[2*i+1] <= node[2*i+2]) ? node[2*i+1] : node[2*i+2];
      end
   end

   assign min_val = node[0];

endmodule
`default_nettype wire

// File: rtl/path_cost_update.sv
`default_nettype none
// ============================================================================
// Module   : path_cost_update
// Purpose  : One-direction SGM recurrence, 4-stage pipeline, freezes on en=0.
// Revision : 1.0 - initial release
// ============================================================================
module path_cost_update
   import sgbm_agg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              in_valid,
   input  logic              line_start,
   input  logic [BUS_W-1:0]  cost_in,
   input  logic [BUS_W-1:0]  prev_path,
   output logic [BUS_W-1:0]  path_out,
   output logic [COST_W-1:0] min_out,
   output logic              valid_out
);

   // Stage 1
   cost_bus_t                s1_cost, s1_prev;
   logic                     s1_valid, s1_ls;
   logic [NGRP*COST_W-1:0]   s1_gmin, gmin_next;
   // Stage 2
   cost_bus_t                s2_cost, s2_m, m_next;
   cost_t                    s2_minlp, minlp_next;
   logic                     s2_valid, s2_ls;
   // Stage 3
   cost_bus_t                s3_cost, s3_t, t_next;
   cost_t                    s3_min, min_s3_next, cap;
   logic                     s3_valid;
   // Stage 4 input
   cost_bus_t                path_next;

   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      disp_min_tree #(.N(GRP), .W(COST_W)) u_grp_min (
         .data    (prev_path[g*GRP*COST_W +: GRP*COST_W]),
         .min_val (gmin_next[g*COST_W +: COST_W])
      );
   end

   disp_min_tree #(.N(NGRP), .W(COST_W)) u_final_min (
      .data    (s1_gmin),
      .min_val (minlp_next)
   );

   assign cap         = sat_add(s2_minlp, P2_C);
   assign min_s3_next = s2_ls ? '0 : s2_minlp;

   for (genvar d = 0; d < DISP; d++) begin : g_disp
      cost_t lp, lo, hi, m, m2, capped;

      assign lp = elem(s1_prev, d);

      // Outermost disparities have no neighbour on one side; all-ones is neutral for min.
      if (d == 0) begin : g_lo_edge
         assign lo = '1;
      end else begin : g_lo
         assign lo = sat_add(elem(s1_prev, d-1), P1_C);
      end

      if (d == DISP-1) begin : g_hi_edge
         assign hi = '1;
      end else begin : g_hi
         assign hi = sat_add(elem(s1_prev, d+1), P1_C);
      end

      assign m = (lp <= lo) ? lp : lo;
      assign m_next[d*COST_W +: COST_W] = (m <= hi) ? m : hi;

      assign m2     = elem(s2_m, d);
      assign capped = (m2 <= cap) ? m2 : cap;
      assign t_next[d*COST_W +: COST_W] = s2_ls ? '0 : (capped - s2_minlp);

      assign path_next[d*COST_W +: COST_W] = sat_add(elem(s3_cost, d), elem(s3_t, d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_cost   <= '1;
         s1_prev   <= '1;
         s1_valid  <= 1'b0;
         s1_ls     <= 1'b1;
         s1_gmin   <= '1;
         s2_cost   <= '1;
         s2_m      <= '1;
         s2_minlp  <= '1;
         s2_valid  <= 1'b0;
         s2_ls     <= 1'b1;
         s3_cost   <= '1;
         s3_t      <= '1;
         s3_min    <= '1;
         s3_valid  <= 1'b0;
         path_out  <= '1;
         min_out   <= '1;
         valid_out <= 1'b0;
      end else if (en) begin
         s1_cost   <= cost_in;
         s1_prev   <= prev_path;
         s1_valid  <= in_valid;
         s1_ls     <= line_start;
         s1_gmin   <= gmin_next;
         s2_cost   <= s1_cost;
         s2_m      <= m_next;
         s2_minlp  <= minlp_next;
         s2_valid  <= s1_valid;
         s2_ls     <= s1_ls;
         s3_cost   <= s2_cost;
         s3_t      <= t_next;
         s3_min    <= min_s3_next;
         s3_valid  <= s2_valid;
         path_out  <= path_next;
         min_out   <= s3_min;
         valid_out <= s3_valid;
      end
   end

endmodule
`default_nettype wire
